// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined 4x4 multiplier between N
// requesters. One operand pair is accepted per cycle, registered onto the
// multiplier inputs, and a tag follows it through the multiplier latency so
// the product is returned to the requester that issued it.
module mul_rr_sched #(
    parameter int N       = 4,
    parameter int MUL_LAT = 4,
    parameter int IDW     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [4*N-1:0]   req_a,
    input  logic [4*N-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_c,
    output logic [N-1:0]     rsp_valid,
    output logic [7:0]       rsp_c,
    output logic [IDW-1:0]   rsp_id,
    output logic             busy,
    output logic [15:0]      issue_cnt
);

    localparam int unsigned NU    = N;
    localparam int unsigned DEPTH = MUL_LAT + 1;

    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_pending;
    logic [3:0]     r_mul_a;
    logic [3:0]     r_mul_b;
    logic           r_tag_vld [DEPTH];
    logic [IDW-1:0] r_tag_id  [DEPTH];
    logic [15:0]    r_issue_cnt;

    logic [N-1:0]   w_elig;
    logic [N-1:0]   w_grant;
    logic           w_accept;
    logic [IDW-1:0] w_gnt_id;
    logic [3:0]     w_sel_a;
    logic [3:0]     w_sel_b;
    logic           w_tail_vld;
    logic [IDW-1:0] w_tail_id;
    logic [N-1:0]   w_rsp_hit;
    logic           w_any_tag;

    // Round-robin search from the pointer upward, wrapping, for the first eligible requester
    always_comb begin
        int unsigned w_idx;
        w_idx    = 0;
        w_grant  = '0;
        w_accept = 1'b0;
        w_gnt_id = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        // Gating with rst_n keeps req_ready low while reset is asserted.
        w_elig   = req_valid & ~r_pending & {N{rst_n}};
        for (int unsigned off = 0; off < NU; off++) begin
            w_idx = ({{(32-IDW){1'b0}}, r_ptr} + off) % NU;
            if (!w_accept && w_elig[w_idx]) begin
                w_accept       = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gnt_id       = IDW'(w_idx);
                w_sel_a        = req_a[4*w_idx +: 4];
                w_sel_b        = req_b[4*w_idx +: 4];
            end
        end
    end

    // Decode the tail tag into the one-hot response and the product return path
    always_comb begin
        w_tail_vld = r_tag_vld[DEPTH-1] & rst_n;
        w_tail_id  = r_tag_id[DEPTH-1];
        w_rsp_hit  = '0;
        w_any_tag  = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            w_rsp_hit[i] = w_tail_vld && (w_tail_id == IDW'(i));
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_any_tag = w_any_tag | r_tag_vld[i];
        end
    end

    // Operand registers, tag pipeline, pending flags, pointer and issue counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_pending   <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_issue_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_id[i]  <= '0;
            end
        end else begin
            r_mul_a      <= w_accept ? w_sel_a : '0;
            r_mul_b      <= w_accept ? w_sel_b : '0;
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= w_accept ? w_gnt_id : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            // A responding requester is still pending this cycle, so it can
            // never be in w_grant at the same time as w_rsp_hit.
            r_pending <= (r_pending & ~w_rsp_hit) | w_grant;
            if (w_accept) begin
                r_ptr <= (w_gnt_id == IDW'(NU-1)) ? '0 : w_gnt_id + IDW'(1);
                if (r_issue_cnt != '1) begin
                    r_issue_cnt <= r_issue_cnt + 16'd1;
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = w_rsp_hit;
    assign rsp_c     = w_tail_vld ? mul_c : '0;
    assign rsp_id    = w_tail_vld ? w_tail_id : '0;
    assign busy      = rst_n & w_any_tag;
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Self-checking bench for mul_rr_sched: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based scheduler model,
// and a second instance driven at full rate to reach counter saturation.
`timescale 1ns/1ps
module tb_mul_rr_sched;

    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int IDW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [4*N-1:0]   req_a;
    logic [4*N-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_c;
    logic [N-1:0]     rsp_valid;
    logic [7:0]       rsp_c;
    logic [IDW-1:0]   rsp_id;
    logic             busy;
    logic [15:0]      issue_cnt;

    // Saturation instance: 8 requesters, latency 1, always valid
    logic             s_rst_n;
    logic [7:0]       s_ready;
    logic [3:0]       s_ma;
    logic [3:0]       s_mb;
    logic [7:0]       s_rv;
    logic [7:0]       s_rc;
    logic [2:0]       s_id;
    logic             s_busy;
    logic [15:0]      s_cnt;

    always #5 clk = ~clk;

    mul_rr_sched #(.N(N), .MUL_LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_c(mul_c), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_id(rsp_id),
        .busy(busy), .issue_cnt(issue_cnt)
    );

    mul_rr_sched #(.N(8), .MUL_LAT(1), .IDW(3)) sat_dut (
        .clk(clk), .rst_n(s_rst_n), .req_valid(8'hFF), .req_a(32'h0),
        .req_b(32'h0), .req_ready(s_ready), .mul_a(s_ma), .mul_b(s_mb),
        .mul_c(8'h00), .rsp_valid(s_rv), .rsp_c(s_rc), .rsp_id(s_id),
        .busy(s_busy), .issue_cnt(s_cnt)
    );

    // Bench multiplier: LAT-stage pipelined 4x4 product
    logic [7:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= {4'h0, mul_a} * {4'h0, mul_b};
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_c = mpipe[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: outstanding operations as a queue with due cycles
    typedef struct {
        int unsigned id;
        logic [7:0]  prod;
        int unsigned due;
        int unsigned iss;
    } op_t;

    op_t         q[$];
    bit          m_pend [N];
    int unsigned m_ptr;
    int unsigned m_cnt;
    logic [3:0]  m_ma;
    logic [3:0]  m_mb;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        m_ma  = 4'h0;
        m_mb  = 4'h0;
    endtask

    task automatic model_step();
        int          g;
        int unsigned idx;
        bit          resp;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        logic [7:0]  exp_c;
        logic [IDW-1:0] exp_id;
        bit          exp_busy;
        logic [3:0]  a;
        logic [3:0]  b;
        g = -1;
        for (int off = 0; off < N; off++) begin
            idx = (m_ptr + off) % N;
            if (g < 0 && rst_n && req_valid[idx] && !m_pend[idx]) g = int'(idx);
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        resp     = rst_n && q.size() > 0 && q[0].due == cyc;
        exp_rv   = '0;
        exp_c    = 8'h00;
        exp_id   = '0;
        if (resp) begin
            exp_rv[q[0].id] = 1'b1;
            exp_c           = q[0].prod;
            exp_id          = IDW'(q[0].id);
        end
        exp_busy = rst_n && q.size() > 0 && q[0].iss < cyc;

        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_id",    32'(rsp_id),    32'(exp_id));
        check("rsp_c",     32'(rsp_c),     32'(exp_c));
        check("busy",      32'(busy),      32'(exp_busy));
        check("mul_a",     32'(mul_a),     32'(m_ma));
        check("mul_b",     32'(mul_b),     32'(m_mb));
        check("issue_cnt", 32'(issue_cnt), m_cnt);

        if (!rst_n) begin
            model_reset();
        end else begin
            if (resp) begin
                m_pend[q[0].id] = 1'b0;
                void'(q.pop_front());
            end
            if (g >= 0) begin
                a = req_a[4*g +: 4];
                b = req_b[4*g +: 4];
                m_pend[g] = 1'b1;
                m_ptr     = (g + 1) % N;
                q.push_back('{id: g, prod: 8'(a) * 8'(b), due: cyc + LAT + 1, iss: cyc});
                m_ma = a;
                m_mb = b;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_ma = 4'h0;
                m_mb = 4'h0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_ops();
        req_a = 16'($urandom);
        req_b = 16'($urandom);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_rst_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        // Single request from requester 0: a=3, b=5
        req_valid = 4'b0001;
        req_a     = 16'h0003;
        req_b     = 16'h0005;
        tick();
        req_valid = '0;
        repeat (8) tick();

        // All requesters valid from pointer 0
        pulse_reset();
        repeat (16) begin
            req_valid = '1;
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Requester 2 re-requests while pending, requester 1 competes
        repeat (16) begin
            req_valid = 4'b0110;
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Pointer wrap: move pointer to 3, then only 3 and 0 valid
        pulse_reset();
        req_valid = 4'b0100;
        rand_ops();
        tick();
        req_valid = '0;
        repeat (7) tick();
        repeat (3) begin
            req_valid = 4'b1001;
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Reset while two operations are in flight
        pulse_reset();
        repeat (2) begin
            req_valid = 4'b0011;
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (2) tick();
        pulse_reset();
        repeat (8) tick();

        // Random traffic with occasional resets
        repeat (400) begin
            req_valid = N'($urandom);
            rand_ops();
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (8) tick();

        // Saturation: one accept per cycle on the 8-requester instance
        s_rst_n = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            @(negedge clk);
            if (k == 0 || k == 1000 || k >= 65533) begin
                check("sat_cnt", 32'(s_cnt), (k > 65535) ? 32'd65535 : 32'(k));
                check("sat_grant", 32'(s_ready != 8'h00), 32'd1);
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
